// File: rtl/timer_irq_dev_pkg.sv
// timer_irq_dev_pkg: register map, CTRL fields, modes and FSM states shared with the bridge and CP0 wiring
package timer_irq_dev_pkg;
    localparam logic [1:0] CTRL_ADDR   = 2'd0;
    localparam logic [1:0] PRESET_ADDR = 2'd1;
    localparam logic [1:0] COUNT_ADDR  = 2'd2;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;
endpackage

// File: rtl/timer_irq_dev.sv
// timer_irq_dev: memory-mapped countdown timer driving one CP0 HWInt line
module timer_irq_dev
    import timer_irq_dev_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);
    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             r_flag;
    state_t           r_state;
    logic             w_wr_reg;
    logic             w_reload;
    logic             w_unused;
    assign w_wr_reg = we && (addr == CTRL_ADDR || addr == PRESET_ADDR);
    assign w_reload = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
    assign w_unused = ^wdata[WIDTH-1:4];
    assign irq      = r_flag & r_ctrl[CTRL_IM];
    always_comb
        rdata = addr == CTRL_ADDR   ? {{(WIDTH-4){1'b0}}, r_ctrl} :
                addr == PRESET_ADDR ? r_preset :
                addr == COUNT_ADDR  ? r_count  : '0;
    // A CTRL/PRESET write is both configuration and the software acknowledge, so it overrides the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
            r_state  <= ST_IDLE;
        end else if (w_wr_reg) begin
            if (addr == CTRL_ADDR) r_ctrl <= wdata[3:0];
            else r_preset <= wdata;
            r_flag  <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (r_ctrl[CTRL_EN]) r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl[CTRL_EN]) r_state <= ST_IDLE;
                    else if (r_count > WIDTH'(1)) r_count <= r_count - WIDTH'(1);
                    else begin
                        r_count <= '0;
                        r_flag  <= 1'b1;
                        r_state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (w_reload) begin
                        r_flag  <= 1'b0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_ctrl[CTRL_EN] <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_irq_dev.sv
// tb_timer_irq_dev: directed and random bus traffic against a closed-form timeline model of the timer
module tb_timer_irq_dev;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic        chk_on = 1'b0;
    int          total = 0;
    int          bad = 0;
    // Model: a run starts at the write edge that leaves EN=1; everything follows from edges since then
    logic [3:0]  m_ctrl = '0;
    logic [31:0] m_preset = '0;
    logic [31:0] m_base = '0;
    logic        m_run = 1'b0;
    longint      m_k = 0;
    logic [31:0] seq [5];

    timer_irq_dev #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic longint per();
        return (m_preset == 0 ? 64'd1 : longint'(m_preset)) + 2;
    endfunction

    function automatic logic is_reload();
        return m_ctrl[2:1] == 2'b01;
    endfunction

    function automatic logic [31:0] exp_count();
        longint n = longint'(m_preset);
        longint p = per();
        longint j;
        if (!m_run || m_k <= 1) return m_base;
        j = is_reload() ? ((m_k - 1) % p) + 1 : m_k;
        return (j >= 2 && j <= p - 1) ? 32'(n - (j - 2)) : 32'd0;
    endfunction

    function automatic logic exp_flag();
        longint p = per();
        if (!m_run) return 1'b0;
        return is_reload() ? (m_k >= 1 && ((m_k - 1) % p) + 1 == p) : (m_k >= p);
    endfunction

    function automatic logic [3:0] exp_ctrl();
        return (m_run && !is_reload() && m_k >= per() + 1) ? {m_ctrl[3:1], 1'b0} : m_ctrl;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        return a == 2'd0 ? {28'd0, exp_ctrl()} : a == 2'd1 ? m_preset : a == 2'd2 ? exp_count() : 32'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ctrl   <= '0;
            m_preset <= '0;
            m_base   <= '0;
            m_run    <= 1'b0;
            m_k      <= 0;
        end else if (we && addr <= 2'd1) begin
            m_base   <= exp_count();
            m_ctrl   <= addr == 2'd0 ? wdata[3:0] : exp_ctrl();
            m_preset <= addr == 2'd1 ? wdata : m_preset;
            m_run    <= addr == 2'd0 ? wdata[0] : exp_ctrl() & 4'b0001 ? 1'b1 : 1'b0;
            m_k      <= 0;
        end else if (m_run) m_k <= m_k + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_rdata", rdata, exp_rd(addr));
            chk("model_irq", {31'd0, irq}, {31'd0, exp_flag() & m_ctrl[3]});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        seq = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1};
        tick(1);
        chk_on = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(0, 0, "rst_ctrl");
        rd(1, 0, "rst_preset");
        rd(2, 0, "rst_count");
        tick(1);
        rd(3, 0, "rst_rsvd");
        chk("rst_irq", {31'd0, irq}, 0);
        wr(1, 5);
        wr(0, 32'h9);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            chk("os_rise", {31'd0, irq}, (i == 7) ? 1 : 0);
        end
        tick(1);
        chk("os_hold", {31'd0, irq}, 1);
        rd(2, 0, "os_count");
        rd(0, 32'h8, "os_ctrl");
        wr(0, 32'h8);
        chk("os_ack", {31'd0, irq}, 0);
        wr(1, 3);
        wr(0, 32'hB);
        addr = 2'd2;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            chk("ar_irq", {31'd0, irq}, (i % 5 == 0) ? 1 : 0);
            chk("ar_cnt", rdata, seq[i % 5]);
        end
        wr(1, 8);
        wr(0, 32'h1);
        tick(6);
        rd(2, 4, "mid_count");
        wr(0, 0);
        tick(3);
        rd(2, 4, "stop_hold");
        chk("stop_irq", {31'd0, irq}, 0);
        wr(0, 32'h9);
        tick(2);
        rd(2, 8, "reen_load");
        wr(0, 0);
        wr(1, 2);
        wr(0, 32'h9);
        tick(3);
        wr(0, 32'h9);
        chk("coll_irq", {31'd0, irq}, 0);
        rd(0, 32'h9, "coll_ctrl");
        wr(0, 0);
        wr(1, 0);
        wr(0, 32'h9);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("p0_rise", {31'd0, irq}, (i == 3) ? 1 : 0);
        end
        wr(0, 32'h8);
        chk("p0_ack", {31'd0, irq}, 0);
        wr(1, 2);
        wr(0, 32'h1);
        tick(5);
        rd(0, 0, "im0_ctrl");
        rd(2, 0, "im0_count");
        chk("im0_irq", {31'd0, irq}, 0);
        wr(1, 20);
        wr(0, 32'h9);
        tick(12);
        rd(2, 10, "pre_rst_count");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(0, 0, "mrst_ctrl");
        rd(1, 0, "mrst_preset");
        rd(2, 0, "mrst_count");
        chk("mrst_irq", {31'd0, irq}, 0);
        tick(5);
        rd(2, 0, "mrst_idle");
        chk("mrst_idle_irq", {31'd0, irq}, 0);
        for (int i = 0; i < 3000; i++) begin
            addr = 2'($urandom_range(0, 3));
            we = $urandom_range(0, 5) == 0;
            wdata = $urandom();
            if (addr == 2'd1) wdata = $urandom_range(0, 7);
            if (addr == 2'd0) wdata[0] = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 499) == 0;
            tick(1);
        end
        we = 1'b0;
        reset = 1'b0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
